// File: rtl/pfb_mac_chain.sv
// rtl/pfb_mac_chain.sv - systolic multiply-add cascade with round/shift/saturate output stage
module pfb_mac_chain #(
    parameter int NUM_TAPS  = 8,
    parameter int A_WIDTH   = 25,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 48,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SHIFT = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         valid_in,
    input  logic [NUM_TAPS*A_WIDTH-1:0]  a,
    input  logic [NUM_TAPS*B_WIDTH-1:0]  b,
    output logic                         valid_out,
    output logic [P_WIDTH-1:0]           p_out,
    output logic [OUT_WIDTH-1:0]         dout,
    output logic                         sat
);

    localparam int M_WIDTH = A_WIDTH + B_WIDTH;
    localparam logic signed [P_WIDTH:0] C_ONE = {{P_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [P_WIDTH:0] C_RND =
        (OUT_SHIFT > 0) ? (C_ONE <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
    localparam logic signed [P_WIDTH:0] C_MAX = (C_ONE <<< (OUT_WIDTH - 1)) - C_ONE;
    localparam logic signed [P_WIDTH:0] C_MIN = -(C_ONE <<< (OUT_WIDTH - 1));

    logic [P_WIDTH-1:0] w_p_casc [0:NUM_TAPS];

    assign w_p_casc[0] = '0;

    // Tap k holds its operands for k+2 cycles: k of skew plus the two operand stages.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic signed [A_WIDTH-1:0] r_a_dly [0:k+1];
        logic signed [B_WIDTH-1:0] r_b_dly [0:k+1];
        logic signed [M_WIDTH-1:0] r_m;
        logic        [P_WIDTH-1:0] r_p;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < k + 2; i++) begin
                    r_a_dly[i] <= '0;
                    r_b_dly[i] <= '0;
                end
                r_m <= '0;
                r_p <= '0;
            end else if (ce) begin
                r_a_dly[0] <= a[k*A_WIDTH +: A_WIDTH];
                r_b_dly[0] <= b[k*B_WIDTH +: B_WIDTH];
                for (int i = 1; i < k + 2; i++) begin
                    r_a_dly[i] <= r_a_dly[i-1];
                    r_b_dly[i] <= r_b_dly[i-1];
                end
                r_m <= M_WIDTH'(r_a_dly[k+1]) * M_WIDTH'(r_b_dly[k+1]);
                r_p <= w_p_casc[k] + P_WIDTH'(r_m);
            end
        end

        assign w_p_casc[k+1] = r_p;
    end

    logic [NUM_TAPS+2:0]     r_vld_sr;
    logic                    r_valid_out;
    logic [P_WIDTH-1:0]      r_p_out;
    logic [OUT_WIDTH-1:0]    r_dout;
    logic                    r_sat;

    logic signed [P_WIDTH:0] w_rnd;
    logic signed [P_WIDTH:0] w_shf;
    logic                    w_hi;
    logic                    w_lo;
    logic [OUT_WIDTH-1:0]    w_dout;

    // Extra top bit keeps the rounding add from overflowing near full scale.
    assign w_rnd  = $signed({w_p_casc[NUM_TAPS][P_WIDTH-1], w_p_casc[NUM_TAPS]}) + C_RND;
    assign w_shf  = w_rnd >>> OUT_SHIFT;
    assign w_hi   = (w_shf > C_MAX);
    assign w_lo   = (w_shf < C_MIN);
    assign w_dout = w_hi ? C_MAX[OUT_WIDTH-1:0] :
                    w_lo ? C_MIN[OUT_WIDTH-1:0] : w_shf[OUT_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_sr    <= '0;
            r_valid_out <= 1'b0;
            r_p_out     <= '0;
            r_dout      <= '0;
            r_sat       <= 1'b0;
        end else if (ce) begin
            r_vld_sr    <= {r_vld_sr[NUM_TAPS+1:0], valid_in};
            r_valid_out <= r_vld_sr[NUM_TAPS+2];
            r_p_out     <= w_p_casc[NUM_TAPS];
            r_dout      <= w_dout;
            r_sat       <= w_hi | w_lo;
        end
    end

    assign valid_out = r_valid_out;
    assign p_out     = r_p_out;
    assign dout      = r_dout;
    assign sat       = r_sat;

endmodule
